c7b_rd_arb: RTL and testbench
=============================

C7B_RD_ARB -- requirements
Module: c7b_rd_arb

Interface
REQ-001 SHALL have parameter ICU_ID, default 4'd0: AXI ID for ICU reads.
REQ-002 SHALL have parameter LSU_ID, default 4'd1: AXI ID for LSU reads.
REQ-003 SHALL have parameter LINE_LEN, default 8'd3: arlen for ICU line fill (4 beats of 64 bits).
REQ-004 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-005 resetn  in  1  reset, asynchronous, active-low.
REQ-006 icu_biu_req  in  1  ICU read request; icu_biu_addr  in  29  address [31:3]; icu_biu_single  in  1  single-beat (uncached) read.
REQ-007 biu_icu_ack  out  1  request accepted; biu_icu_data_valid  out  1  beat valid; biu_icu_data_last  out  1  final beat; biu_icu_data  out  64  beat data; biu_icu_fault  out  1  beat error.
REQ-008 lsu_biu_rd_req  in  1  LSU read request; lsu_biu_rd_addr  in  32  byte address.
REQ-009 biu_lsu_rd_ack  out  1  accepted; biu_lsu_data_valid  out  1  data valid; biu_lsu_data  out  64  data.
REQ-010 arvalid out 1; arready in 1; arid out 4; araddr out 32; arlen out 8; arsize out 3; arburst out 2: AXI read-address channel.
REQ-011 rvalid in 1; rready out 1; rid in 4; rdata in 64; rresp in 2; rlast in 1: AXI read-data channel.

Function
REQ-012 SHALL run FSM IDLE, ADDR, DATA; exactly one read transaction outstanding at a time.
REQ-013 IDLE: any request present -> latch winner, payload, ID; ADDR next cycle (req at cycle N -> arvalid at N+1).
REQ-014 Tie (both requests in same IDLE cycle): winner is the requester not granted last (round-robin); single request always wins.
REQ-015 ICU payload: araddr={icu_biu_addr,3'b000}, arlen=single?0:LINE_LEN, arid=ICU_ID; LSU payload: araddr=lsu_biu_rd_addr, arlen=0, arid=LSU_ID.
REQ-016 arsize SHALL be constant 3'b011 and arburst constant 2'b01 (INCR).
REQ-017 ADDR: arvalid=1 with payload stable from registers until arready; no payload change or withdrawal while waiting.
REQ-018 Winner's ack SHALL pulse one cycle, combinationally, in the arvalid&arready cycle; FSM -> DATA next cycle.
REQ-019 Request deasserted after grant does not cancel; transaction completes normally.
REQ-020 rready=1 only in DATA; 0 in IDLE/ADDR.
REQ-021 DATA: beat with rvalid and rid==latched ID forwarded same cycle to winner only: data_valid=1, data=rdata; ICU data_last=rlast.
REQ-022 Beat with rid!=latched ID SHALL be accepted and dropped, no output, no counter change.
REQ-023 8-bit beat counter cleared on ADDR exit, +1 per matching beat.
REQ-024 biu_icu_fault=1 on a matching ICU beat if rresp!=2'b00, or rlast=1 with counter!=arlen, or counter==arlen with rlast=0.
REQ-025 LSU error responses SHALL be forwarded as data without indication.
REQ-026 Matching beat with rlast=1 -> IDLE next cycle; last-grant pointer updated to winner at that time.
REQ-027 New request pending at return to IDLE -> arvalid one cycle later (one idle bubble minimum).
REQ-028 Non-winner outputs SHALL stay 0 throughout.

Reset
REQ-029 resetn low SHALL asynchronously force IDLE, counter 0, last-grant=ICU (LSU wins first tie), all outputs 0 except arsize/arburst constants.
REQ-030 Reset mid-transaction SHALL abandon it; no acks or data after release until new request.

Verification
REQ-031 ICU line fill, addr 29'h0000_0200, arready immediate -> araddr 32'h1000, arlen 3, arid 0, ack pulse, 4 data_valid beats, last on beat 4, fault 0.
REQ-032 Both request at cycle 0 after reset -> LSU granted first (arid 1, arlen 0), ICU granted after LSU rlast; repeat tie -> LSU and ICU alternate.
REQ-033 arready held 0 for 5 cycles -> arvalid and araddr stable all 5 cycles, ack exactly once.
REQ-034 ICU line fill with rlast on beat 2 -> fault=1 that beat, FSM returns IDLE; rresp=2'b10 on beat 1 -> fault on beat 1 only.
REQ-035 During LSU read, rvalid with rid=4'd5 -> dropped, no LSU data_valid; subsequent rid=1 rlast beat delivered.
REQ-036 resetn low during DATA -> rready 0, outputs 0 immediately; post-release ICU single read -> arlen 0, one beat with last=1.

Source files
------------

// File: rtl/c7b_rd_arb_if.sv
// Signal bundle between the read arbiter, its two requesters (ICU, LSU) and the AXI read channels.
// Handshakes: an AXI beat transfers on a rising edge where valid && ready; once raised, valid and payload hold until that edge.
interface c7b_rd_arb_if;
    logic        icu_biu_req;
    logic [28:0] icu_biu_addr;
    logic        icu_biu_single;
    logic        biu_icu_ack;
    logic        biu_icu_data_valid;
    logic        biu_icu_data_last;
    logic [63:0] biu_icu_data;
    logic        biu_icu_fault;

    logic        lsu_biu_rd_req;
    logic [31:0] lsu_biu_rd_addr;
    logic        biu_lsu_rd_ack;
    logic        biu_lsu_data_valid;
    logic [63:0] biu_lsu_data;

    logic        arvalid;
    logic        arready;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;

    logic        rvalid;
    logic        rready;
    logic [3:0]  rid;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;

    // master: the arbiter (serves ICU/LSU, drives AXI AR, sinks AXI R)
    modport master (
        input  icu_biu_req, icu_biu_addr, icu_biu_single,
        output biu_icu_ack, biu_icu_data_valid, biu_icu_data_last, biu_icu_data, biu_icu_fault,
        input  lsu_biu_rd_req, lsu_biu_rd_addr,
        output biu_lsu_rd_ack, biu_lsu_data_valid, biu_lsu_data,
        output arvalid, arid, araddr, arlen, arsize, arburst,
        input  arready,
        input  rvalid, rid, rdata, rresp, rlast,
        output rready
    );

    // slave: requesters plus the AXI memory side
    modport slave (
        output icu_biu_req, icu_biu_addr, icu_biu_single,
        input  biu_icu_ack, biu_icu_data_valid, biu_icu_data_last, biu_icu_data, biu_icu_fault,
        output lsu_biu_rd_req, lsu_biu_rd_addr,
        input  biu_lsu_rd_ack, biu_lsu_data_valid, biu_lsu_data,
        input  arvalid, arid, araddr, arlen, arsize, arburst,
        output arready,
        output rvalid, rid, rdata, rresp, rlast,
        input  rready
    );
endinterface

// File: rtl/c7b_rd_arb.sv
// Round-robin arbiter merging ICU and LSU reads onto one AXI read port,
// with a single transaction outstanding at a time.
module c7b_rd_arb #(
    parameter logic [3:0] ICU_ID   = 4'd0,
    parameter logic [3:0] LSU_ID   = 4'd1,
    parameter logic [7:0] LINE_LEN = 8'd3
) (
    input  logic              clk,
    input  logic              resetn,
    c7b_rd_arb_if.master      bus,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t      state;
    logic        win_lsu;
    logic        last_lsu;
    logic        arvalid_q;
    logic        rready_q;
    logic [31:0] ar_addr_q;
    logic [7:0]  ar_len_q;
    logic [3:0]  ar_id_q;
    logic [7:0]  beat_cnt;

    logic        pick_lsu;
    logic        ar_hs;
    logic        beat_match;
    logic        icu_beat;
    logic        lsu_beat;
    logic        icu_err;

    // On a tie the requester that was not granted last wins
    assign pick_lsu   = bus.lsu_biu_rd_req & (~bus.icu_biu_req | ~last_lsu);
    assign ar_hs      = arvalid_q & bus.arready;
    assign beat_match = rready_q & bus.rvalid & (bus.rid == ar_id_q);
    assign icu_beat   = beat_match & ~win_lsu;
    assign lsu_beat   = beat_match & win_lsu;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            win_lsu   <= 1'b0;
            last_lsu  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            ar_addr_q <= 32'd0;
            ar_len_q  <= 8'd0;
            ar_id_q   <= 4'd0;
            beat_cnt  <= 8'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.icu_biu_req || bus.lsu_biu_rd_req) begin
                        win_lsu   <= pick_lsu;
                        arvalid_q <= 1'b1;
                        state     <= ST_ADDR;
                        if (pick_lsu) begin
                            ar_addr_q <= bus.lsu_biu_rd_addr;
                            ar_len_q  <= 8'd0;
                            ar_id_q   <= LSU_ID;
                        end else begin
                            ar_addr_q <= {bus.icu_biu_addr, 3'b000};
                            ar_len_q  <= bus.icu_biu_single ? 8'd0 : LINE_LEN;
                            ar_id_q   <= ICU_ID;
                        end
                    end
                end
                ST_ADDR: begin
                    if (bus.arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        beat_cnt  <= 8'd0;
                        state     <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    // Beats tagged with a foreign ID are consumed (rready high) but ignored
                    if (beat_match) begin
                        beat_cnt <= beat_cnt + 8'd1;
                        if (bus.rlast) begin
                            rready_q <= 1'b0;
                            last_lsu <= win_lsu;
                            state    <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    arvalid_q <= 1'b0;
                    rready_q  <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

    // A line fill must end exactly on beat LINE_LEN+1; early or late rlast is a fault
    assign icu_err = (bus.rresp != 2'b00)
                   | (bus.rlast & (beat_cnt != ar_len_q))
                   | (~bus.rlast & (beat_cnt == ar_len_q));

    assign bus.arvalid = arvalid_q;
    assign bus.araddr  = ar_addr_q;
    assign bus.arlen   = ar_len_q;
    assign bus.arid    = ar_id_q;
    assign bus.arsize  = 3'b011;
    assign bus.arburst = 2'b01;
    assign bus.rready  = rready_q;

    assign bus.biu_icu_ack        = ar_hs & ~win_lsu;
    assign bus.biu_icu_data_valid = icu_beat;
    assign bus.biu_icu_data_last  = icu_beat & bus.rlast;
    assign bus.biu_icu_data       = icu_beat ? bus.rdata : 64'd0;
    assign bus.biu_icu_fault      = icu_beat & icu_err;

    assign bus.biu_lsu_rd_ack     = ar_hs & win_lsu;
    assign bus.biu_lsu_data_valid = lsu_beat;
    assign bus.biu_lsu_data       = lsu_beat ? bus.rdata : 64'd0;

    assign dbg_state = state;

endmodule

// File: tb/tb_c7b_rd_arb.sv
// Directed bench for c7b_rd_arb: expected AR requests and data beats are queued by the
// stimulus and consumed by a negedge monitor.
module tb_c7b_rd_arb;

  logic       clk = 1'b0;
  logic       resetn;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  c7b_rd_arb_if bus ();

  c7b_rd_arb #(
    .ICU_ID  (4'd0),
    .LSU_ID  (4'd1),
    .LINE_LEN(8'd3)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .bus      (bus),
    .dbg_state(dbg_state)
  );

  // {is_lsu, arid, araddr, arlen}
  logic [44:0] exp_ar_q[$];
  // {fault, last, data}
  logic [65:0] exp_icu_q[$];
  logic [63:0] exp_lsu_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: output seen with empty expected queue at %0t", name, $time);
  endtask

  // ---------------- monitor ----------------
  logic        ar_wait_q;
  logic [43:0] prev_ar;
  logic [44:0] e_ar;
  logic [65:0] e_icu;
  logic [63:0] e_lsu;

  always @(negedge clk) begin
    if (!resetn) begin
      ar_wait_q <= 1'b0;
    end else begin
      if (ar_wait_q)
        check("ar_stable", 128'({bus.arvalid, bus.arid, bus.araddr, bus.arlen}), 128'({1'b1, prev_ar}));
      ar_wait_q <= bus.arvalid & ~bus.arready;
      prev_ar   <= {bus.arid, bus.araddr, bus.arlen};

      if (bus.arvalid)
        check("rready_in_addr", 128'(bus.rready), 128'(0));

      if (bus.arvalid && bus.arready) begin
        if (exp_ar_q.size() == 0) unexpected("ar_handshake");
        else begin
          e_ar = exp_ar_q.pop_front();
          check("ar_payload", 128'({bus.arid, bus.araddr, bus.arlen}), 128'(e_ar[43:0]));
          check("ar_ack", 128'({bus.biu_icu_ack, bus.biu_lsu_rd_ack}), e_ar[44] ? 128'(2'b01) : 128'(2'b10));
          check("ar_const", 128'({bus.arsize, bus.arburst}), 128'({3'b011, 2'b01}));
        end
      end else begin
        check("no_stray_ack", 128'({bus.biu_icu_ack, bus.biu_lsu_rd_ack}), 128'(0));
      end

      if (bus.biu_icu_data_valid) begin
        if (exp_icu_q.size() == 0) unexpected("icu_beat");
        else begin
          e_icu = exp_icu_q.pop_front();
          check("icu_beat", 128'({bus.biu_icu_fault, bus.biu_icu_data_last, bus.biu_icu_data}), 128'(e_icu));
        end
      end else begin
        check("icu_quiet", 128'({bus.biu_icu_fault, bus.biu_icu_data_last, bus.biu_icu_data}), 128'(0));
      end

      if (bus.biu_lsu_data_valid) begin
        if (exp_lsu_q.size() == 0) unexpected("lsu_beat");
        else begin
          e_lsu = exp_lsu_q.pop_front();
          check("lsu_beat", 128'(bus.biu_lsu_data), 128'(e_lsu));
        end
      end else begin
        check("lsu_quiet", 128'(bus.biu_lsu_data), 128'(0));
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_ar(input logic is_lsu, input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
    exp_ar_q.push_back({is_lsu, id, addr, len});
  endtask

  task automatic push_icu(input logic fault, input logic last, input logic [63:0] d);
    exp_icu_q.push_back({fault, last, d});
  endtask

  // Wait (bounded) for arvalid, stall arready for 'delay' cycles, then accept for one cycle
  task automatic do_ar(input int delay);
    int t = 0;
    while (!bus.arvalid && t < 20) begin
      tick();
      t++;
    end
    check("arvalid_seen", 128'(bus.arvalid), 128'(1));
    repeat (delay) tick();
    bus.arready = 1'b1;
    tick();
    bus.arready = 1'b0;
  endtask

  task automatic beat(input logic [3:0] id, input logic [63:0] d, input logic [1:0] resp, input logic last);
    bus.rvalid = 1'b1;
    bus.rid    = id;
    bus.rdata  = d;
    bus.rresp  = resp;
    bus.rlast  = last;
    tick();
    bus.rvalid = 1'b0;
    bus.rlast  = 1'b0;
    bus.rresp  = 2'b00;
  endtask

  task automatic icu_line(input logic [28:0] a, input logic single);
    bus.icu_biu_req    = 1'b1;
    bus.icu_biu_addr   = a;
    bus.icu_biu_single = single;
  endtask

  task automatic lsu_rd(input logic [31:0] a);
    bus.lsu_biu_rd_req  = 1'b1;
    bus.lsu_biu_rd_addr = a;
  endtask

  // Tie: expected winner first, loser after winner's rlast; both single-beat
  task automatic tie(input logic lsu_first, input logic [28:0] ia, input logic [31:0] la,
                     input logic [63:0] di, input logic [63:0] dl);
    if (lsu_first) begin
      push_ar(1'b1, 4'd1, la, 8'd0); exp_lsu_q.push_back(dl);
      push_ar(1'b0, 4'd0, {ia, 3'b000}, 8'd0); push_icu(1'b0, 1'b1, di);
    end else begin
      push_ar(1'b0, 4'd0, {ia, 3'b000}, 8'd0); push_icu(1'b0, 1'b1, di);
      push_ar(1'b1, 4'd1, la, 8'd0); exp_lsu_q.push_back(dl);
    end
    icu_line(ia, 1'b1);
    lsu_rd(la);
    do_ar(0);
    if (lsu_first) begin bus.lsu_biu_rd_req = 1'b0; beat(4'd1, dl, 2'b00, 1'b1); end
    else           begin bus.icu_biu_req    = 1'b0; beat(4'd0, di, 2'b00, 1'b1); end
    do_ar(0);
    if (lsu_first) begin bus.icu_biu_req    = 1'b0; beat(4'd0, di, 2'b00, 1'b1); end
    else           begin bus.lsu_biu_rd_req = 1'b0; beat(4'd1, dl, 2'b00, 1'b1); end
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    resetn              = 1'b0;
    bus.icu_biu_req     = 1'b0;
    bus.icu_biu_addr    = 29'd0;
    bus.icu_biu_single  = 1'b0;
    bus.lsu_biu_rd_req  = 1'b0;
    bus.lsu_biu_rd_addr = 32'd0;
    bus.arready         = 1'b0;
    bus.rvalid          = 1'b0;
    bus.rid             = 4'd0;
    bus.rdata           = 64'd0;
    bus.rresp           = 2'b00;
    bus.rlast           = 1'b0;
    repeat (3) tick();

    check("reset_ar", 128'({bus.arvalid, bus.arid, bus.araddr, bus.arlen, bus.rready}), 128'(0));
    check("reset_clients", 128'({bus.biu_icu_ack, bus.biu_icu_data_valid, bus.biu_icu_data_last,
          bus.biu_icu_fault, bus.biu_icu_data, bus.biu_lsu_rd_ack, bus.biu_lsu_data_valid, bus.biu_lsu_data}), 128'(0));
    check("reset_const", 128'({bus.arsize, bus.arburst}), 128'({3'b011, 2'b01}));
    check("reset_state", 128'(dbg_state), 128'(0));
    resetn = 1'b1;
    tick();

    // Tie right after reset: LSU first, then ICU; repeat gives the same order
    tie(1'b1, 29'h0000_0300, 32'h0000_4008, 64'h1111_0000_0000_0001, 64'h2222_0000_0000_0001);
    tie(1'b1, 29'h0000_0301, 32'h0000_4010, 64'h1111_0000_0000_0002, 64'h2222_0000_0000_0002);
    // After an LSU-only grant the next tie goes to ICU
    push_ar(1'b1, 4'd1, 32'h0000_5000, 8'd0); exp_lsu_q.push_back(64'h3333_0000_0000_0001);
    lsu_rd(32'h0000_5000);
    do_ar(0);
    bus.lsu_biu_rd_req = 1'b0;
    beat(4'd1, 64'h3333_0000_0000_0001, 2'b00, 1'b1);
    tick();
    tie(1'b0, 29'h0000_0302, 32'h0000_4018, 64'h1111_0000_0000_0003, 64'h2222_0000_0000_0003);

    // ICU line fill, immediate arready
    push_ar(1'b0, 4'd0, 32'h0000_1000, 8'd3);
    for (int i = 0; i < 4; i++) push_icu(1'b0, i == 3, 64'hA000_0000_0000_0000 + 64'(i));
    icu_line(29'h0000_0200, 1'b0);
    do_ar(0);
    bus.icu_biu_req = 1'b0;
    for (int i = 0; i < 4; i++) beat(4'd0, 64'hA000_0000_0000_0000 + 64'(i), 2'b00, i == 3);
    tick();

    // arready stalled 5 cycles; request withdrawn right after it is latched
    push_ar(1'b0, 4'd0, 32'h0000_55E0, 8'd0); push_icu(1'b0, 1'b1, 64'hB000_0000_0000_0001);
    icu_line(29'h0000_0ABC, 1'b1);
    tick();
    bus.icu_biu_req = 1'b0;
    do_ar(5);
    beat(4'd0, 64'hB000_0000_0000_0001, 2'b00, 1'b1);
    tick();

    // Early rlast on beat 2
    push_ar(1'b0, 4'd0, 32'h0000_0080, 8'd3);
    push_icu(1'b0, 1'b0, 64'hC000_0000_0000_0001);
    push_icu(1'b1, 1'b1, 64'hC000_0000_0000_0002);
    icu_line(29'h0000_0010, 1'b0);
    do_ar(0);
    bus.icu_biu_req = 1'b0;
    beat(4'd0, 64'hC000_0000_0000_0001, 2'b00, 1'b0);
    beat(4'd0, 64'hC000_0000_0000_0002, 2'b00, 1'b1);
    check("idle_after_early_last", 128'(dbg_state), 128'(0));
    tick();

    // Error response on beat 1 only
    push_ar(1'b0, 4'd0, 32'h0000_0100, 8'd3);
    for (int i = 0; i < 4; i++) push_icu(i == 0, i == 3, 64'hD000_0000_0000_0000 + 64'(i));
    icu_line(29'h0000_0020, 1'b0);
    do_ar(0);
    bus.icu_biu_req = 1'b0;
    for (int i = 0; i < 4; i++) beat(4'd0, 64'hD000_0000_0000_0000 + 64'(i), (i == 0) ? 2'b10 : 2'b00, i == 3);
    tick();

    // Missing rlast on beat 4, late rlast on beat 5
    push_ar(1'b0, 4'd0, 32'h0000_0180, 8'd3);
    for (int i = 0; i < 5; i++) push_icu(i >= 3, i == 4, 64'hE000_0000_0000_0000 + 64'(i));
    icu_line(29'h0000_0030, 1'b0);
    do_ar(0);
    bus.icu_biu_req = 1'b0;
    for (int i = 0; i < 5; i++) beat(4'd0, 64'hE000_0000_0000_0000 + 64'(i), 2'b00, i == 4);
    tick();

    // Foreign-ID beat dropped during LSU read; LSU error response forwarded as plain data
    push_ar(1'b1, 4'd1, 32'h0000_0104, 8'd0); exp_lsu_q.push_back(64'hF000_0000_0000_0002);
    lsu_rd(32'h0000_0104);
    do_ar(0);
    bus.lsu_biu_rd_req = 1'b0;
    beat(4'd5, 64'hF000_0000_0000_0001, 2'b00, 1'b1);
    beat(4'd1, 64'hF000_0000_0000_0002, 2'b10, 1'b1);
    tick();

    // Foreign-ID beat must not advance the ICU beat counter
    push_ar(1'b0, 4'd0, 32'h0000_0400, 8'd0); push_icu(1'b0, 1'b1, 64'hF100_0000_0000_0002);
    icu_line(29'h0000_0080, 1'b1);
    do_ar(0);
    bus.icu_biu_req = 1'b0;
    beat(4'd5, 64'hF100_0000_0000_0001, 2'b00, 1'b1);
    beat(4'd0, 64'hF100_0000_0000_0002, 2'b00, 1'b1);
    tick();

    // Reset during DATA
    push_ar(1'b0, 4'd0, 32'h0000_0200, 8'd3);
    push_icu(1'b0, 1'b0, 64'h9000_0000_0000_0001);
    icu_line(29'h0000_0040, 1'b0);
    do_ar(0);
    bus.icu_biu_req = 1'b0;
    beat(4'd0, 64'h9000_0000_0000_0001, 2'b00, 1'b0);
    bus.rvalid = 1'b1;
    bus.rid    = 4'd0;
    bus.rdata  = 64'h9000_0000_0000_0002;
    resetn     = 1'b0;
    #1;
    check("rst_rready", 128'({bus.rready, bus.arvalid}), 128'(0));
    check("rst_icu_out", 128'({bus.biu_icu_data_valid, bus.biu_icu_data_last, bus.biu_icu_fault, bus.biu_icu_data}), 128'(0));
    check("rst_state", 128'(dbg_state), 128'(0));
    check("rst_const", 128'({bus.arsize, bus.arburst}), 128'({3'b011, 2'b01}));
    repeat (2) tick();
    resetn = 1'b1;
    repeat (2) tick();
    bus.rvalid = 1'b0;
    tick();

    // Fresh single read after the abandoned fill
    push_ar(1'b0, 4'd0, 32'h0000_91A0, 8'd0); push_icu(1'b0, 1'b1, 64'h8000_0000_0000_0001);
    icu_line(29'h0000_1234, 1'b1);
    do_ar(0);
    bus.icu_biu_req = 1'b0;
    beat(4'd0, 64'h8000_0000_0000_0001, 2'b00, 1'b1);
    repeat (3) tick();

    check("ar_drained", 128'(exp_ar_q.size()), 128'(0));
    check("icu_drained", 128'(exp_icu_q.size()), 128'(0));
    check("lsu_drained", 128'(exp_lsu_q.size()), 128'(0));
    check("final_state", 128'(dbg_state), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
